// File: rtl/adder_ring_meter_if.sv
// Control/result bundle between the logic-analyser side and adder_ring_meter.
// ADDER_RING_METER_ACCUM_EN adds the clear input and the run_cnt result.
interface adder_ring_meter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 24,
    parameter int unsigned WIN_W = 16
);
    logic             active;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIN_W-1:0] window;
    logic             chain_in;
    logic             ring_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [WIDTH:0]   sum;
`ifdef ADDER_RING_METER_ACCUM_EN
    logic             clear;
    logic [7:0]       run_cnt;

    modport master (
        output active, start, a_in, b_in, window, chain_in, clear,
        input  ring_en, busy, done, count, overflow, sum, run_cnt
    );
    modport slave (
        input  active, start, a_in, b_in, window, chain_in, clear,
        output ring_en, busy, done, count, overflow, sum, run_cnt
    );
`else
    modport master (
        output active, start, a_in, b_in, window, chain_in,
        input  ring_en, busy, done, count, overflow, sum
    );
    modport slave (
        input  active, start, a_in, b_in, window, chain_in,
        output ring_en, busy, done, count, overflow, sum
    );
`endif
endinterface

// File: rtl/adder_ring_meter.sv
// Ring-oscillation edge counter plus registered sum for an instrumented adder.
// Define ADDER_RING_METER_ACCUM_EN to accumulate counts across runs (clear/run_cnt).
module adder_ring_meter #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CNT_W  = 24,
    parameter int unsigned WIN_W  = 16,
    parameter int unsigned SETTLE = 4
) (
    input logic             wb_clk_i,
    input logic             wb_rst_n,
    adder_ring_meter_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;

    state_t           state;
    logic             sync1, sync2, sync3;
    logic             rise_c;
    logic             last_c;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] phase_cnt;

    // chain_in is asynchronous: two flops to resolve, a third for edge detection
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= bus.chain_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise_c = sync2 & ~sync3;

    // final cycle of ARM (zero window) or of COUNT
    assign last_c = (phase_cnt == '0) &&
                    ((state == COUNT) || ((state == ARM) && (win_q == '0)));

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state        <= IDLE;
            win_q        <= '0;
            phase_cnt    <= '0;
            bus.ring_en  <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.count    <= '0;
            bus.overflow <= 1'b0;
            bus.sum      <= '0;
`ifdef ADDER_RING_METER_ACCUM_EN
            bus.run_cnt  <= '0;
`endif
        end else begin
            bus.done <= 1'b0;
            if (!bus.active) begin
                state       <= IDLE;
                bus.ring_en <= 1'b0;
                bus.busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
`ifdef ADDER_RING_METER_ACCUM_EN
                        if (bus.clear) begin
                            bus.count    <= '0;
                            bus.overflow <= 1'b0;
                            bus.run_cnt  <= '0;
                        end
`endif
                        if (bus.start) begin
                            win_q       <= bus.window;
                            bus.sum     <= (WIDTH+1)'(bus.a_in) + (WIDTH+1)'(bus.b_in);
`ifndef ADDER_RING_METER_ACCUM_EN
                            bus.count    <= '0;
                            bus.overflow <= 1'b0;
`endif
                            phase_cnt   <= SETTLE_LAST;
                            state       <= ARM;
                            bus.ring_en <= 1'b1;
                            bus.busy    <= 1'b1;
                        end
                    end
                    ARM: begin
                        if (phase_cnt != '0) begin
                            phase_cnt <= phase_cnt - 1'b1;
                        end else if (win_q != '0) begin
                            state     <= COUNT;
                            phase_cnt <= win_q - 1'b1;
                        end
                    end
                    COUNT: begin
                        if (rise_c) begin
                            if (bus.count != CNT_MAX) bus.count <= bus.count + 1'b1;
                            if (bus.count >= CNT_MAX - 1'b1) bus.overflow <= 1'b1;
                        end
                        if (phase_cnt != '0) phase_cnt <= phase_cnt - 1'b1;
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase

                // end of window overrides the per-state next-state choice
                if (last_c) begin
                    state       <= DONE;
                    bus.done    <= 1'b1;
                    bus.ring_en <= 1'b0;
                    bus.busy    <= 1'b0;
`ifdef ADDER_RING_METER_ACCUM_EN
                    if (bus.run_cnt != 8'hFF) bus.run_cnt <= bus.run_cnt + 1'b1;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_adder_ring_meter.sv
// Self-checking bench for adder_ring_meter: vector table, scoreboard, corner sequences.
module tb_adder_ring_meter;
    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CNT_W  = 24;
    localparam int unsigned WIN_W  = 16;
    localparam int unsigned SETTLE = 4;
    localparam int unsigned SAT_W  = 4;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIN_W-1:0] w;
        int               period;
        int               edges;
    } vec_t;

    typedef struct {
        logic [WIDTH:0] sum;
        int             cnt;
        logic           ovf;
        int             scnt;
        logic           sovf;
        int             done_cyc;
        int             ring_base;
        int             ring_exp;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic chain = 1'b0;
    int   ph = 0;
    int   period = 0;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    int   ring_total = 0;
    int   done_cnt = 0;
    int   acc_base = 0;
    exp_t sb[$];
`ifdef ADDER_RING_METER_ACCUM_EN
    bit   use_clear = 1'b1;
`endif

    always #5 clk = ~clk;

    adder_ring_meter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();
    adder_ring_meter_if #(.WIDTH(WIDTH), .CNT_W(SAT_W), .WIN_W(WIN_W)) sbus ();

    assign bus.chain_in  = chain;
    assign sbus.chain_in = chain;
    assign sbus.active   = bus.active;
    assign sbus.start    = bus.start;
    assign sbus.a_in     = bus.a_in;
    assign sbus.b_in     = bus.b_in;
    assign sbus.window   = bus.window;
`ifdef ADDER_RING_METER_ACCUM_EN
    assign sbus.clear    = bus.clear;
`endif

    adder_ring_meter #(.WIDTH(WIDTH), .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE(SETTLE)) u_dut (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .bus      (bus)
    );

    adder_ring_meter #(.WIDTH(WIDTH), .CNT_W(SAT_W), .WIN_W(WIN_W), .SETTLE(SETTLE)) u_sat (
        .wb_clk_i (clk),
        .wb_rst_n (rst_n),
        .bus      (sbus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous chain stimulus: toggles every period/2 clocks
    always @(negedge clk) begin
        if (period == 0) begin
            chain <= 1'b0;
            ph    <= 0;
        end else if (ph >= period / 2 - 1) begin
            chain <= ~chain;
            ph    <= 0;
        end else begin
            ph <= ph + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // scoreboard: every done pulse must match the oldest outstanding run
    always @(negedge clk) begin
        exp_t e;
        if (bus.ring_en) ring_total++;
        if (bus.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk("done_cycle",   64'(cyc), 64'(e.done_cyc));
                chk("count",        64'(bus.count), 64'(e.cnt));
                chk("overflow",     64'(bus.overflow), 64'(e.ovf));
                chk("sum_hold",     64'(bus.sum), 64'(e.sum));
                chk("ring_cycles",  64'(ring_total - e.ring_base), 64'(e.ring_exp));
                chk("sat_count",    64'(sbus.count), 64'(e.scnt));
                chk("sat_overflow", 64'(sbus.overflow), 64'(e.sovf));
            end
        end
    end

    task automatic launch(input vec_t v, input bit push);
        exp_t e;
        @(negedge clk);
        period     = v.period;
        bus.a_in   = v.a;
        bus.b_in   = v.b;
        bus.window = v.w;
        bus.start  = 1'b1;
`ifdef ADDER_RING_METER_ACCUM_EN
        bus.clear  = use_clear;
`endif
        e.sum       = (WIDTH+1)'(v.a) + (WIDTH+1)'(v.b);
        e.cnt       = acc_base + v.edges;
        e.ovf       = (e.cnt >= (1 << CNT_W) - 1);
        e.scnt      = (e.cnt > (1 << SAT_W) - 1) ? (1 << SAT_W) - 1 : e.cnt;
        e.sovf      = (e.cnt >= (1 << SAT_W) - 1);
        e.done_cyc  = cyc + 1 + int'(SETTLE) + int'(v.w);
        e.ring_base = ring_total;
        e.ring_exp  = int'(SETTLE) + int'(v.w);
        if (push) sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
`ifdef ADDER_RING_METER_ACCUM_EN
        bus.clear = 1'b0;
`endif
        chk("sum_t_plus_1", 64'(bus.sum), 64'(e.sum));
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == d0) begin
            chk("done_timeout", 64'(done_cnt - d0), 64'd1);
            sb.delete();
        end
    endtask

    vec_t vecs[5];
    vec_t v;
    int   d_before;

    initial begin
        vecs[0] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0001, w: 16'd8,  period: 0, edges: 0};
        vecs[1] = '{a: 32'h1234_5678, b: 32'h9ABC_DEF0, w: 16'd16, period: 4, edges: 4};
        vecs[2] = '{a: 32'h0000_0000, b: 32'h0000_0000, w: 16'd0,  period: 2, edges: 0};
        vecs[3] = '{a: 32'h8000_0000, b: 32'h8000_0000, w: 16'd64, period: 2, edges: 32};
        vecs[4] = '{a: 32'hDEAD_BEEF, b: 32'h0000_0000, w: 16'd1,  period: 0, edges: 0};

        bus.active = 1'b1;
        bus.start  = 1'b0;
        bus.a_in   = '0;
        bus.b_in   = '0;
        bus.window = '0;
`ifdef ADDER_RING_METER_ACCUM_EN
        bus.clear  = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_ring_en",  64'(bus.ring_en), 64'd0);
        chk("rst_busy",     64'(bus.busy), 64'd0);
        chk("rst_done",     64'(bus.done), 64'd0);
        chk("rst_count",    64'(bus.count), 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        chk("rst_sum",      64'(bus.sum), 64'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            launch(vecs[i], 1'b1);
            wait_done(200);
        end

        // second start during COUNT: ignored, one done, original operands kept
        v = '{a: 32'h0000_0005, b: 32'h0000_0007, w: 16'd8, period: 4, edges: 2};
        d_before = done_cnt;
        launch(v, 1'b1);
        repeat (SETTLE + 1) @(negedge clk);
        bus.a_in   = 32'hFFFF_FFFF;
        bus.b_in   = 32'hFFFF_FFFF;
        bus.window = 16'd3;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        chk("busy_start_sum", 64'(bus.sum), 64'h0C);
        chk("busy_start_busy", 64'(bus.busy), 64'd1);
        wait_done(200);
        repeat (20) @(posedge clk);
        chk("single_done", 64'(done_cnt - d_before), 64'd1);

        // inactive in IDLE: start ignored
        @(negedge clk);
        bus.active = 1'b0;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        chk("inactive_busy", 64'(bus.busy), 64'd0);
        chk("inactive_ring", 64'(bus.ring_en), 64'd0);
        @(negedge clk);
        bus.active = 1'b1;

        // abort on the third COUNT cycle
        v = '{a: 32'h0000_0010, b: 32'h0000_0020, w: 16'd16, period: 4, edges: 0};
        d_before = done_cnt;
        launch(v, 1'b0);
        repeat (SETTLE + 2) @(negedge clk);
        chk("abort_pre_busy", 64'(bus.busy), 64'd1);
        bus.active = 1'b0;
        @(negedge clk);
        chk("abort_ring_en", 64'(bus.ring_en), 64'd0);
        chk("abort_busy",    64'(bus.busy), 64'd0);
        repeat (24) @(posedge clk);
        chk("abort_no_done", 64'(done_cnt - d_before), 64'd0);
        @(negedge clk);
        bus.active = 1'b1;

        // asynchronous reset mid-COUNT with chain toggling
        v = '{a: 32'h0000_1111, b: 32'h0000_2222, w: 16'd32, period: 2, edges: 0};
        launch(v, 1'b0);
        repeat (SETTLE + 4) @(negedge clk);
        chk("mid_count_nonzero", 64'(bus.count != '0), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ring_en",  64'(bus.ring_en), 64'd0);
        chk("arst_busy",     64'(bus.busy), 64'd0);
        chk("arst_count",    64'(bus.count), 64'd0);
        chk("arst_overflow", 64'(bus.overflow), 64'd0);
        chk("arst_sum",      64'(bus.sum), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", 64'(bus.busy), 64'd0);
        launch(vecs[1], 1'b1);
        wait_done(200);

`ifdef ADDER_RING_METER_ACCUM_EN
        launch(vecs[1], 1'b1);
        wait_done(200);
        use_clear = 1'b0;
        acc_base  = 4;
        launch(vecs[1], 1'b1);
        wait_done(200);
        @(negedge clk);
        chk("accum_run_cnt", 64'(bus.run_cnt), 64'd2);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        chk("clear_count",   64'(bus.count), 64'd0);
        chk("clear_run_cnt", 64'(bus.run_cnt), 64'd0);
`endif

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/adder_ring_meter.md
Name: adder_ring_meter

Overview:
- Parametrised measurement controller for instrumented adders.
- Launches a carry-chain ring oscillation on the adder under test and counts oscillation edges over a programmable gate window.
- Also returns the registered arithmetic result, so functional and delay checks come from one block.
- Sits inside the wrapped instrumented-adder projects, between logic-analyser control bits and the adder chain.

Parameters:
- WIDTH, 32, operand/sum width of the adder under test.
- CNT_W, 24, edge-counter width.
- WIN_W, 16, gate-window length width, in clock cycles.
- SETTLE, 4, cycles between ring enable and start of counting (1..15).

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_n  in  1  reset, asynchronous, active-low.
- active  in  1  project select; low forces abort to IDLE.
- start  in  1  one-cycle run request.
- a_in  in  WIDTH  operand A.
- b_in  in  WIDTH  operand B.
- window  in  WIN_W  gate length in cycles.
- chain_in  in  1  raw ring/chain output; asynchronous to wb_clk_i.
- ring_en  out  1  enables the ring oscillation in the adder under test.
- busy  out  1  high in ARM/COUNT.
- done  out  1  one-cycle pulse when a result is ready.
- count  out  CNT_W  rising edges counted in the last window.
- overflow  out  1  count saturated during the last run.
- sum  out  WIDTH+1  registered {carry, a+b}.

Behaviour:
- Reset (asynchronous, any state, including mid-run): FSM=IDLE; ring_en, busy, done, overflow = 0; count = 0; sum = 0; synchroniser flops = 0.
- chain_in passes through a 2-flop synchroniser, then a rising-edge detector (sync2 & ~sync3).
- FSM states: IDLE, ARM, COUNT, DONE.
- IDLE:
  - start && active at cycle t: latch a_in/b_in/window; sum = a_in+b_in (full WIDTH+1 result) valid at t+1.
  - count and overflow cleared; next state ARM.
- ARM:
  - ring_en=1, busy=1.
  - Stays exactly SETTLE cycles; edges are not counted.
  - Latched window==0 -> DONE directly (count stays 0).
  - Otherwise -> COUNT.
- COUNT:
  - ring_en=1, busy=1; lasts exactly latched-window cycles.
  - Each detected rising edge increments count.
  - At all-ones, count saturates and overflow=1.
- DONE:
  - One cycle; done=1, ring_en=0, busy=0; next state IDLE.
  - count/overflow/sum hold until the next accepted start.
- start while busy or in DONE: ignored; latched operands and window are unaffected.
- active low in any state: next cycle IDLE, ring_en=0, busy=0, no done pulse. Partial count remains visible.
- active low in IDLE: start ignored.
- Total latency from start cycle t: done at t+1+SETTLE+window (window>0), or t+1+SETTLE (window=0).
- Edges arriving in the last COUNT cycle through synchroniser latency are lost; accepted ±0 rule: only detector pulses asserted during COUNT cycles count.

Optional Feature:
- Macro: ADDER_RING_METER_ACCUM_EN.
- With the macro defined:
  - Adds input clear (1) and output run_cnt (8).
  - count and overflow are NOT cleared at start; they accumulate across runs.
  - run_cnt increments (saturating at 255) on each done pulse.
  - clear in IDLE zeroes count, overflow and run_cnt the next cycle; clear elsewhere is ignored.
  - clear and start in the same IDLE cycle: clear takes effect, start is accepted, and the run counts from 0.
- Without the macro: count cleared on each accepted start; ports clear and run_cnt do not exist.

Test Plan:
- Reset mid-COUNT with chain toggling:
  - wb_rst_n low -> all outputs 0 immediately (asynchronous).
  - After release, FSM IDLE and busy=0.
- Arithmetic, WIDTH=32, a=32'hFFFF_FFFF, b=1, window=8:
  - sum=33'h1_0000_0000 one cycle after start.
  - done exactly 1+4+8 cycles after start.
- Counting, chain_in toggling synchronously every 2 clocks (period 4), window=16, SETTLE=4:
  - count=4, overflow=0; ring_en high for exactly 20 cycles.
- Boundary cases:
  - window=0 -> done at t+5 with count=0.
  - Second start during COUNT is ignored; a single done pulse.
- Saturation, CNT_W=4, chain period 2, window=64:
  - count=15, overflow=1.
- Abort: active dropped on cycle 3 of COUNT -> IDLE next cycle, ring_en=0, no done.
- Accumulation (ADDER_RING_METER_ACCUM_EN):
  - Two runs of the counting scenario -> count=8, run_cnt=2.
  - clear -> count=0 and run_cnt=0 next cycle.
